// File: rtl/fos_pkg.sv
// Shared definitions for the first-order-section inverse: default widths,
// control FSM states and radix-4 Booth digit decoding.
package fos_pkg;

  localparam int FOS_DATA_W = 32;
  localparam int FOS_COEF_W = 11;

  // Control FSM states of the inverse section.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Radix-4 Booth digit: selects 0, +/-a or +/-2a as the partial product.
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4
  } booth_e;

  // Decode a multiplier triplet {b[2i+1], b[2i], b[2i-1]} into a Booth digit.
  function automatic booth_e booth_decode(input logic [2:0] trip);
    booth_e d;
    case (trip)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle.
// prod holds the low DATA_W bits of the signed product a*b and is valid
// while done pulses, N_DIG cycles after start.
module booth_r4_seq
  import fos_pkg::*;
#(
  parameter int DATA_W = FOS_DATA_W,
  parameter int COEF_W = FOS_COEF_W,
  parameter int N_DIG  = (COEF_W + 1) / 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [COEF_W-1:0] b,
  output logic [DATA_W-1:0] prod,
  output logic              done
);

  // Multiplier register holds b with an appended zero below bit 0 and at
  // least one sign-extension bit above, so every triplet is well defined.
  localparam int BW    = 2 * N_DIG + 2;
  localparam int EXT   = BW - COEF_W - 1;
  localparam int CNT_W = $clog2(N_DIG) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_DIG - 1);

  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] acc_q;
  logic [BW-1:0]     mplr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;

  booth_e            dig;
  logic [DATA_W-1:0] pp;

  // Partial product for the current digit; mcand_q is already shifted by 2i.
  always_comb begin
    dig = booth_decode(mplr_q[2:0]);
    pp  = '0;
    case (dig)
      P1:      pp = mcand_q;
      P2:      pp = mcand_q << 1;
      M1:      pp = -mcand_q;
      M2:      pp = -(mcand_q << 1);
      default: pp = '0;
    endcase
  end

  // Load operands on start, then accumulate one digit per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        mcand_q <= a;
        mplr_q  <= {{EXT{b[COEF_W-1]}}, b, 1'b0};
        acc_q   <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        acc_q   <= acc_q + pp;
        mcand_q <= mcand_q << 2;
        mplr_q  <= {{2{mplr_q[BW-1]}}, mplr_q[BW-1:2]};
        cnt_q   <= cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign prod = acc_q;
  assign done = done_q;

endmodule

// File: rtl/fos_inverse_seq.sv
// Sequential inverse of the first-order section:
//   x[n] = y[n] + x[n-1] - a1*y[n-1]   (all modulo 2^DATA_W)
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; a producer holding valid keeps its data stable until then,
// and x_out/out_valid never change while out_valid=1 and out_ready=0.
module fos_inverse_seq
  import fos_pkg::*;
#(
  parameter int DATA_W = FOS_DATA_W,
  parameter int COEF_W = FOS_COEF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] y_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] a1,
  input  logic              clr,
  output logic [DATA_W-1:0] x_out,
  output logic              out_valid,
  input  logic              out_ready
);

  state_e            state_q;
  state_e            state_d;
  logic              accept;
  logic              mul_done;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] x_new;
  logic [DATA_W-1:0] y_prev_q;
  logic [DATA_W-1:0] x_prev_q;
  logic [DATA_W-1:0] y_cur_q;
  logic [DATA_W-1:0] x_out_q;
  logic              out_valid_q;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;

  // A clear coinciding with an accept wins, so the multiplier sees zero history.
  assign mul_a = clr ? '0 : y_prev_q;
  assign x_new = y_cur_q + x_prev_q - prod;

  // The multiplier latches a1 at start, so it acts as a1_cur for the whole
  // computation; later a1 changes only matter at the next accept.
  booth_r4_seq #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .a     (mul_a),
    .b     (a1),
    .prod  (prod),
    .done  (mul_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = MULT;
      MULT:    if (mul_done) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // History, captured sample and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      y_prev_q    <= '0;
      x_prev_q    <= '0;
      y_cur_q     <= '0;
      x_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr) begin
            y_prev_q <= '0;
            x_prev_q <= '0;
          end
          if (accept) y_cur_q <= y_in;
        end
        MULT: begin
          if (mul_done) begin
            x_out_q     <= x_new;
            x_prev_q    <= x_new;
            y_prev_q    <= y_cur_q;
            out_valid_q <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  assign x_out     = x_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fos_inverse_seq.sv
// Bench for fos_inverse_seq: directed table, backpressure, mid-operation
// reset and randomized samples against an arithmetic reference model.
module tb_fos_inverse_seq;

  localparam int DATA_W = 32;
  localparam int COEF_W = 11;
  localparam int LAT    = 7;
  localparam int TMO    = 50;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] y_in = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [COEF_W-1:0] a1 = '0;
  logic              clr = 1'b0;
  logic [DATA_W-1:0] x_out;
  logic              out_valid;
  logic              out_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_xp = '0;
  logic [DATA_W-1:0] m_yp = '0;

  typedef struct {
    logic [DATA_W-1:0] y;
    logic [COEF_W-1:0] a;
    bit                c;
    logic [DATA_W-1:0] x;
  } vec_t;

  vec_t vecs[10];

  fos_inverse_seq dut (
    .clk       (clk),
    .reset     (reset),
    .y_in      (y_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a1        (a1),
    .clr       (clr),
    .x_out     (x_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  // Reference model: recurrence evaluated with 64-bit signed arithmetic.
  task automatic model_accept(input logic [DATA_W-1:0] y,
                              input logic [COEF_W-1:0] a, input bit c);
    longint p;
    logic [DATA_W-1:0] x;
    if (c) begin
      m_xp = '0;
      m_yp = '0;
    end
    p = longint'($signed(a)) * longint'($signed(m_yp));
    x = y + m_xp - p[DATA_W-1:0];
    m_yp = y;
    m_xp = x;
    exp_q.push_back(x);
  endtask

  // Present a sample and return #1 after the edge that accepted it.
  task automatic accept_sample(input logic [DATA_W-1:0] y,
                               input logic [COEF_W-1:0] a, input bit c);
    int g;
    @(negedge clk);
    y_in = y;
    a1 = a;
    clr = c;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < TMO) begin
      @(negedge clk);
      g++;
    end
    check("in_ready_wait", 32'(g < TMO), 32'd1);
    model_accept(y, a, c);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr = 1'b0;
  endtask

  // Wait for out_valid, check latency and value against the scoreboard.
  task automatic wait_out(output logic [DATA_W-1:0] exp_x);
    int lat;
    lat = 0;
    while (!out_valid && lat < TMO) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(LAT));
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      exp_x = '0;
    end else begin
      exp_x = exp_q.pop_front();
      check("x_out", x_out, exp_x);
    end
  endtask

  // Full transaction with bp cycles of output backpressure.
  task automatic do_sample(input logic [DATA_W-1:0] y, input logic [COEF_W-1:0] a,
                           input bit c, input int bp, output logic [DATA_W-1:0] got);
    logic [DATA_W-1:0] exp_x;
    @(negedge clk);
    out_ready = (bp == 0);
    accept_sample(y, a, c);
    wait_out(exp_x);
    got = x_out;
    for (int k = 0; k < bp; k++) begin
      @(posedge clk);
      #1;
      check("bp_x_hold", x_out, exp_x);
      check("bp_valid_hold", 32'(out_valid), 32'd1);
    end
    if (bp > 0) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("x_after_drop", x_out, exp_x);
  endtask

  initial begin
    logic [DATA_W-1:0] got;
    logic [DATA_W-1:0] exp_bp;
    int vcount;

    vecs[0] = '{32'd10,         11'd3,     1'b1, 32'd10};
    vecs[1] = '{32'd40,         11'd3,     1'b0, 32'd20};
    vecs[2] = '{32'd93,         11'd3,     1'b0, 32'hFFFF_FFF9};
    vecs[3] = '{32'h7FFF_FFFF,  11'd0,     1'b1, 32'h7FFF_FFFF};
    vecs[4] = '{32'd1,          11'd0,     1'b0, 32'h8000_0000};
    vecs[5] = '{32'd2,          11'h400,   1'b1, 32'd2};
    vecs[6] = '{32'd0,          11'h400,   1'b0, 32'd2050};
    vecs[7] = '{32'd10,         11'd3,     1'b1, 32'd10};
    vecs[8] = '{32'd40,         11'd3,     1'b0, 32'd20};
    vecs[9] = '{32'd9,          11'd3,     1'b1, 32'd9};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_x_out", x_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table: round trip, wrap, negative coefficient, clr.
    for (int i = 0; i < 10; i++) begin
      do_sample(vecs[i].y, vecs[i].a, vecs[i].c, 0, got);
      check($sformatf("table_%0d", i), got, vecs[i].x);
    end

    // Backpressure with the next input already waiting.
    @(negedge clk);
    out_ready = 1'b0;
    accept_sample(32'd100, 11'd2, 1'b0);
    wait_out(exp_bp);
    @(negedge clk);
    y_in = 32'd55;
    a1 = 11'd2;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("bp_x_stable", x_out, exp_bp);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    model_accept(32'd55, 11'd2, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_next_accepted", 32'(in_ready), 32'd0);
    wait_out(exp_bp);
    @(posedge clk);
    #1;
    check("bp_next_drop", 32'(out_valid), 32'd0);

    // Reset three cycles into MULT.
    accept_sample(32'd77, 11'd5, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_x_out", x_out, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    m_xp = '0;
    m_yp = '0;
    vcount = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) vcount++;
    end
    check("midrst_no_output", 32'(vcount), 32'd0);
    do_sample(32'd5, 11'd7, 1'b0, 0, got);
    check("midrst_next", got, 32'd5);

    // Randomized samples.
    for (int i = 0; i < 40; i++) begin
      do_sample($urandom(), 11'($urandom_range(0, 2047)),
                ($urandom_range(0, 7) == 0), $urandom_range(0, 3), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
